// File: rtl/dpsk_pkg.sv
// dpsk_pkg: shared types and constants for the DPSK demapper/packer.
package dpsk_pkg;
    typedef struct packed {
        logic signed [15:0] i;
        logic signed [15:0] q;
    } iq16_t;
    localparam logic [2:0] MODE_DBPSK = 3'd0;
    localparam logic [2:0] MODE_DQPSK = 3'd1;
    localparam logic [7:0] CSR_CTRL   = 8'h00;
    localparam logic [7:0] CSR_STATUS = 8'h04;
    localparam logic [7:0] CSR_SYMCNT = 8'h08;
endpackage

// File: rtl/dpsk_demap_packer_if.sv
// dpsk_demap_packer_if: increment stream in, byte stream out, AXI4-Lite CSR port.
interface dpsk_demap_packer_if;
    import dpsk_pkg::*;
    logic        in_valid;
    logic        in_ready;
    iq16_t       in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [7:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [7:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output in_ready, out_valid, out_data, out_last,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        output s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  in_ready, out_valid, out_data, out_last,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/dpsk_slicer.sv
// dpsk_slicer: hard decision of one phase increment to 1 (DBPSK) or 2 Gray bits (DQPSK).
module dpsk_slicer
    import dpsk_pkg::*;
(
    input  iq16_t      iq,
    input  logic [2:0] mode,
    output logic [1:0] nbits,
    output logic [1:0] bits
);
    logic [16:0] ai, aq;
    logic        dq, i_axis;
    // 17-bit magnitudes so -32768 becomes +32768 instead of wrapping
    always_comb begin
        ai     = iq.i[15] ? 17'd0 - {iq.i[15], iq.i} : {iq.i[15], iq.i};
        aq     = iq.q[15] ? 17'd0 - {iq.q[15], iq.q} : {iq.q[15], iq.q};
        i_axis = ai >= aq;
        dq     = mode != MODE_DBPSK;
        nbits  = dq ? 2'd2 : 2'd1;
        bits   = !dq ? {1'b0, iq.i[15]} : i_axis ? {2{iq.i[15]}} : {iq.q[15], ~iq.q[15]};
    end
endmodule

// File: rtl/dpsk_demap_packer.sv
// dpsk_demap_packer: slices DPSK phase increments and packs the decided bits
// MSB-first into bytes, with AXI4-Lite control/status registers.
module dpsk_demap_packer
    import dpsk_pkg::*;
#(
    parameter int SYMCNT_W = 32
) (
    input logic                s_axi_aclk,
    input logic                s_axi_aresetn,
    dpsk_demap_packer_if.slave bus
);
    logic                enable_q, enable_d, swrst_q, swrst_d;
    logic [2:0]          mode_q, mode_d, mode_act_q, mode_act_d, eff_mode;
    logic                running_q, running_d, pad_q, pad_d;
    logic [SYMCNT_W-1:0] sym_q, sym_d;
    logic [7:0]          sr_q, sr_d, out_data_q, out_data_d, sh;
    logic [3:0]          cnt_q, cnt_d, tot;
    logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [31:0]         rdata_q, rdata_d, rmux;
    logic [1:0]          nbits, bits;
    logic                in_ready, fire, emit, wr, rd, wr_ctrl, wr_stat;
    logic                unused_wdata;

    assign unused_wdata = ^{bus.s_axi_wdata[31:7], bus.s_axi_wdata[3]};

    // a beat arriving at a byte boundary already uses the newly written mode
    assign eff_mode = cnt_q == 4'd0 ? mode_q : mode_act_q;

    dpsk_slicer u_slicer (
        .iq   (bus.in_data),
        .mode (eff_mode),
        .nbits(nbits),
        .bits (bits)
    );

    assign in_ready = enable_q & ~swrst_q & (~out_valid_q | bus.out_ready);
    assign fire     = bus.in_valid & in_ready;
    assign wr       = bus.s_axi_awvalid & bus.s_axi_wvalid & ~bvalid_q;
    assign rd       = bus.s_axi_arvalid & ~rvalid_q;
    assign wr_ctrl  = wr & (bus.s_axi_awaddr == CSR_CTRL);
    assign wr_stat  = wr & (bus.s_axi_awaddr == CSR_STATUS);

    always_comb begin
        tot         = cnt_q + {2'b00, nbits};
        sh          = nbits == 2'd2 ? {sr_q[5:0], bits} : {sr_q[6:0], bits[0]};
        emit        = fire & ((tot == 4'd8) | bus.in_last);
        enable_d    = wr_ctrl ? bus.s_axi_wdata[0] : enable_q;
        mode_d      = wr_ctrl ? bus.s_axi_wdata[6:4] : mode_q;
        swrst_d     = wr_ctrl & bus.s_axi_wdata[2];
        running_d   = emit | (running_q & ~(wr_stat & bus.s_axi_wdata[0]));
        pad_d       = (emit & (tot != 4'd8)) | (pad_q & ~(wr_stat & bus.s_axi_wdata[1]));
        sr_d        = (swrst_q | emit) ? 8'd0 : fire ? sh : sr_q;
        cnt_d       = (swrst_q | emit) ? 4'd0 : fire ? tot : cnt_q;
        mode_act_d  = swrst_q ? mode_q : eff_mode;
        out_valid_d = ~swrst_q & (emit | (out_valid_q & ~bus.out_ready));
        out_data_d  = emit ? sh << (4'd8 - tot) : out_data_q;
        out_last_d  = emit ? bus.in_last : out_last_q;
        sym_d       = swrst_q ? '0 : (fire & ~&sym_q) ? sym_q + SYMCNT_W'(1) : sym_q;
        bvalid_d    = wr | (bvalid_q & ~bus.s_axi_bready);
        rvalid_d    = rd | (rvalid_q & ~bus.s_axi_rready);
        rmux        = bus.s_axi_araddr == CSR_CTRL   ? {25'd0, mode_q, 3'd0, enable_q} :
                      bus.s_axi_araddr == CSR_STATUS ? {30'd0, pad_q, running_q} :
                      bus.s_axi_araddr == CSR_SYMCNT ? 32'(sym_q) : 32'd0;
        rdata_d     = rd ? rmux : rdata_q;
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            enable_q    <= 1'b0;
            mode_q      <= MODE_DQPSK;
            mode_act_q  <= MODE_DQPSK;
            swrst_q     <= 1'b0;
            running_q   <= 1'b0;
            pad_q       <= 1'b0;
            sym_q       <= '0;
            sr_q        <= 8'd0;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            mode_act_q  <= mode_act_d;
            swrst_q     <= swrst_d;
            running_q   <= running_d;
            pad_q       <= pad_d;
            sym_q       <= sym_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_last      = out_last_q;
    assign bus.s_axi_awready = ~bvalid_q;
    assign bus.s_axi_wready  = ~bvalid_q;
    assign bus.s_axi_bresp   = 2'b00;
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_arready = ~rvalid_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.s_axi_rresp   = 2'b00;
    assign bus.s_axi_rvalid  = rvalid_q;
endmodule

// File: tb/tb_dpsk_demap_packer.sv
// tb_dpsk_demap_packer: directed vectors with hand-computed bytes and CSR values.
module tb_dpsk_demap_packer;
    import dpsk_pkg::*;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] rv;
    int          t2i[8] = '{100, -100, 100, 100, -100, -100, -100, 100};
    int          t6i[8] = '{100, -100, -100, 100, 100, -100, 100, -100};

    dpsk_demap_packer_if bus();
    dpsk_demap_packer #(.SYMCNT_W(32)) dut (.s_axi_aclk(clk), .s_axi_aresetn(rstn), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.s_axi_awaddr = a;
        bus.s_axi_wdata = d;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid = 1'b0;
    endtask

    task automatic rd_csr(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.s_axi_araddr = a;
        bus.s_axi_arvalid = 1'b1;
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
        chk("rvalid", bus.s_axi_rvalid, 1);
        d = bus.s_axi_rdata;
    endtask

    task automatic send(input int i, input int q, input logic last);
        int k = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = {16'(i), 16'(q)};
        bus.in_last = last;
        #1;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 50) chk("in_ready_timeout", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_data"}, bus.out_data, d);
        chk({tag, "_last"}, bus.out_last, l);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 1;
        bus.s_axi_awaddr = 0; bus.s_axi_awvalid = 0; bus.s_axi_wdata = 0; bus.s_axi_wvalid = 0;
        bus.s_axi_bready = 1; bus.s_axi_araddr = 0; bus.s_axi_arvalid = 0; bus.s_axi_rready = 1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_awready", bus.s_axi_awready, 1);
        chk("rst_wready", bus.s_axi_wready, 1);
        chk("rst_arready", bus.s_axi_arready, 1);
        chk("rst_bvalid", bus.s_axi_bvalid, 0);
        chk("rst_rvalid", bus.s_axi_rvalid, 0);
        rd_csr(CSR_CTRL, rv);   chk("rst_ctrl", rv, 32'h10);
        rd_csr(CSR_STATUS, rv); chk("rst_status", rv, 0);
        rd_csr(CSR_SYMCNT, rv); chk("rst_symcnt", rv, 0);

        // DQPSK, one symbol per quadrant
        wr(CSR_CTRL, 32'h11);
        rd_csr(CSR_CTRL, rv); chk("ctrl_rb", rv, 32'h11);
        send(32767, 0, 0);
        chk("t1_partial", bus.out_valid, 0);
        send(0, 32767, 0);
        send(-32767, 0, 0);
        send(0, -32767, 0);
        expect_byte("t1", 8'h1E, 0);

        // DBPSK byte, then tie and full-scale cases
        wr(CSR_CTRL, 32'h01);
        for (int j = 0; j < 8; j++) send(t2i[j], 0, 0);
        expect_byte("t2", 8'h4E, 0);
        send(-1, 0, 0);
        send(0, 0, 1);
        expect_byte("t2_tie", 8'h80, 1);
        wr(CSR_CTRL, 32'h11);
        send(-32768, -32768, 0);
        send(32767, -32768, 1);
        expect_byte("t2_fs", 8'hE0, 1);
        rd_csr(CSR_SYMCNT, rv); chk("t2_symcnt", rv, 16);

        // padded frame end and W1C status
        wr(CSR_STATUS, 32'h3);
        rd_csr(CSR_STATUS, rv); chk("t3_status_clr", rv, 0);
        send(0, 32767, 0);
        send(0, 32767, 0);
        send(0, 32767, 1);
        expect_byte("t3", 8'h54, 1);
        rd_csr(CSR_STATUS, rv); chk("t3_status", rv, 3);

        // backpressure then accept in the drain cycle
        bus.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) send(0, -32767, 0);
        expect_byte("t4", 8'hAA, 0);
        repeat (10) @(negedge clk);
        chk("t4_stall_in_ready", bus.in_ready, 0);
        chk("t4_stall_valid", bus.out_valid, 1);
        chk("t4_stall_data", bus.out_data, 8'hAA);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = {16'd0, 16'(-32767)};
        bus.in_last = 1'b0;
        #1;
        chk("t4_drain_in_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t4_drained", bus.out_valid, 0);
        for (int j = 0; j < 3; j++) send(32767, 0, 0);
        expect_byte("t4b", 8'h80, 0);

        // mode change mid-byte waits for the byte boundary
        wr(CSR_CTRL, 32'h01);
        send(-100, 0, 0);
        send(100, 0, 0);
        send(-100, 0, 0);
        wr(CSR_CTRL, 32'h11);
        send(-1, 32767, 0);
        send(-1, 32767, 0);
        send(1, 32767, 0);
        send(1, 32767, 0);
        chk("t5_partial", bus.out_valid, 0);
        send(-1, 32767, 0);
        expect_byte("t5a", 8'hB9, 0);
        for (int j = 0; j < 4; j++) send(0, 32767, 0);
        expect_byte("t5b", 8'h55, 0);

        // software reset with a partial byte held
        wr(CSR_CTRL, 32'h01);
        for (int j = 0; j < 5; j++) send(-100, 0, 0);
        wr(CSR_CTRL, 32'h05);
        chk("t6_swrst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("t6_after_in_ready", bus.in_ready, 1);
        rd_csr(CSR_CTRL, rv); chk("t6_ctrl", rv, 32'h01);
        for (int j = 0; j < 8; j++) begin
            send(t6i[j], 0, 0);
            if (j == 2) chk("t6_partial", bus.out_valid, 0);
        end
        expect_byte("t6", 8'h65, 0);
        rd_csr(CSR_SYMCNT, rv); chk("t6_symcnt", rv, 8);

        // asynchronous reset with a byte pending
        bus.out_ready = 1'b0;
        send(-100, 0, 1);
        expect_byte("t7", 8'h80, 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_data", bus.out_data, 0);
        chk("arst_out_last", bus.out_last, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        rd_csr(CSR_CTRL, rv);   chk("arst_ctrl", rv, 32'h10);
        rd_csr(CSR_SYMCNT, rv); chk("arst_symcnt", rv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
